// File: rtl/fpu_seq_pkg.sv
// Shared encodings for the FPU issue/writeback sequencer: op codes, FSM states,
// fixed latencies and the canonical NaN used when square root is compiled out.
package fpu_seq_pkg;

  localparam logic [3:0] OP_FADD    = 4'd0;
  localparam logic [3:0] OP_FSUB    = 4'd1;
  localparam logic [3:0] OP_FMUL    = 4'd2;
  localparam logic [3:0] OP_FDIV    = 4'd3;
  localparam logic [3:0] OP_FSGNJ   = 4'd4;
  localparam logic [3:0] OP_FMINMAX = 4'd5;
  localparam logic [3:0] OP_FSQRT   = 4'd6;
  localparam logic [3:0] OP_FCMP    = 4'd7;
  localparam logic [3:0] OP_FCVT_WS = 4'd8;
  localparam logic [3:0] OP_FCVT_SW = 4'd9;

  localparam logic [4:0] LAT_ADD = 5'd3;
  localparam logic [4:0] LAT_MUL = 5'd4;
  localparam logic [4:0] LAT_1   = 5'd1;
  localparam logic [4:0] LAT_CVT = 5'd2;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_lat_rom.sv
// Combinational op -> {latency, illegal} lookup. FPU_SQRT_EN selects whether
// op 6 is a real square root or an illegal single-cycle op.
module fpu_lat_rom
  import fpu_seq_pkg::*;
#(
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic [3:0] op_i,
  output logic [4:0] lat_o,
  output logic       illegal_o
);

  always_comb begin
    lat_o     = LAT_1;
    illegal_o = 1'b0;
    case (op_i)
      OP_FADD, OP_FSUB:           lat_o = LAT_ADD;
      OP_FMUL:                    lat_o = LAT_MUL;
      OP_FDIV:                    lat_o = 5'(DIV_LAT);
      OP_FSGNJ, OP_FMINMAX, OP_FCMP: lat_o = LAT_1;
`ifdef FPU_SQRT_EN
      OP_FSQRT:                   lat_o = 5'(SQRT_LAT);
`else
      OP_FSQRT:                   illegal_o = 1'b1;
`endif
      OP_FCVT_WS, OP_FCVT_SW:     lat_o = LAT_CVT;
      default:                    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// EX-stage FPU issue/writeback sequencer: latches an op, stalls for its latency,
// then strobes a one-cycle writeback. Square root is enabled by FPU_SQRT_EN.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [4:0]      rd,
  input  logic            int_dest,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic [XLEN-1:0] fpu_result,
  output logic [3:0]      fpu_op,
  output logic [XLEN-1:0] fpu_a,
  output logic [XLEN-1:0] fpu_b,
  output logic            stall,
  output logic            wb_valid,
  output logic            wb_int,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output state_e          dbg_state_o
);

  // Handshake: start is a one-cycle pulse accepted only in IDLE/DONE without
  // flush; stall holds upstream in the start cycle and every BUSY cycle;
  // wb_valid is high for the single DONE cycle and needs no acknowledge.

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic              int_q, int_d;
  logic              ill_q, ill_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic [4:0]        lat;
  logic              lat_ill;
  logic              accept;
  logic [XLEN-1:0]   fill;

  fpu_lat_rom #(
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT)
  ) u_lat_rom (
    .op_i      (op),
    .lat_o     (lat),
    .illegal_o (lat_ill)
  );

`ifdef FPU_SQRT_EN
  assign fill = '0;
`else
  // A compiled-out square root still returns a well-formed float.
  assign fill = (op_q == OP_FSQRT) ? XLEN'(CANON_NAN) : '0;
`endif

  assign accept = start & ~flush & (state_q != BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    int_d     = int_q;
    ill_d     = ill_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = lat - 5'd1;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          rd_d    = rd;
          int_d   = int_dest;
          ill_d   = lat_ill;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d   = DONE;
          wb_data_d = ill_q ? fill : fpu_result;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      int_q     <= 1'b0;
      ill_q     <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      int_q     <= int_d;
      ill_q     <= ill_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign stall       = start | (state_q == BUSY);
  assign wb_valid    = (state_q == DONE);
  assign illegal     = (state_q == DONE) & ill_q;
  assign wb_int      = int_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Multi-cycle issue and writeback sequencer for floating-point operations decoded with fpuOp set. It sits in EX, directly downstream of the control unit. It accepts the 4-bit {fpuOp,aluOp} operation code plus operands and destination, latches them into the FPU datapath, and stalls the pipeline for an op-dependent latency. It then presents a one-cycle writeback to the float or integer register file.

## Interface
- `XLEN`, default 32: operand and result width.
- `DIV_LAT`, default 16: FDIV.S latency in cycles (range 1–31).
- `SQRT_LAT`, default 16: FSQRT.S latency in cycles (range 1–31).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle issue pulse. Sent only on the first EX cycle of an FPU instruction.
- `op` in 4: {fpuOp,aluOp}, values 0–9 as decoded upstream.
- `rd` in 5: destination register index.
- `int_dest` in 1: destination is the integer file (the decoded regWrite bit; FCVT.W.S).
- `src_a`, `src_b` in XLEN: operands.
- `flush` in 1: kill the in-flight op.
- `fpu_result` in XLEN: result from the FPU datapath.
- `fpu_op` out 4: latched op.
- `fpu_a`, `fpu_b` out XLEN: latched operands.
- `stall` out 1: hold the upstream pipeline.
- `wb_valid` out 1: one-cycle writeback strobe.
- `wb_int` out 1: writeback targets the integer file.
- `wb_rd` out 5: writeback register index.
- `wb_data` out XLEN: writeback data.
- `illegal` out 1: pulses with `wb_valid` when the op is unsupported.

## Operation
- **States:** IDLE, BUSY, DONE. Counter `cnt` is 5 bits.
- **Latency L per op:**
  - 0/1 add/sub: 3.
  - 2 mul: 4.
  - 3 div: DIV_LAT.
  - 4 sign-inject, 5 min/max, 7 compare: 1.
  - 6 sqrt: SQRT_LAT.
  - 8/9 convert: 2.
  - 10–15: 1, and the op is marked illegal.
- **IDLE or DONE with `start` high:**
  - Latch `op`, `src_a`, `src_b`, `rd`, `int_dest`.
  - Load `cnt` = L−1 and go to BUSY.
- **BUSY:** decrement `cnt`. When `cnt`==0, capture data into `wb_data` and go to DONE.
  - Legal op: capture `fpu_result`.
  - Illegal op: capture 0.
- **DONE:**
  - `wb_valid`=1 for exactly one cycle.
  - Next state is IDLE, or BUSY if `start` is high (back-to-back issue).
- **`stall`** = `start` | (state==BUSY). It is combinational and low in DONE, so the pipeline advances in the writeback cycle.
- **`flush`:**
  - In BUSY: go to IDLE with no `wb_valid`; latched outputs keep their values.
  - In DONE: no effect, writeback completes.
  - `flush` and `start` in the same cycle: `flush` wins, the op is not accepted, and `stall` is still high that cycle.
- **`start` while BUSY:** protocol violation; ignored, state unchanged.
- **Reset:** state IDLE, `cnt` 0. All outputs are 0: `fpu_op`, `fpu_a`, `fpu_b`, `wb_*`, `illegal`, `stall` (with `start` low).
- **Reset mid-operation:** aborts immediately with no writeback.

## Timing
- `start` sampled high at edge E0 → `wb_valid` is high in the cycle after edge E0+L, i.e. L+1 cycles after the `start` cycle.
- `fpu_a`, `fpu_b`, `fpu_op` are valid from the cycle after E0 and stable through DONE.
- The datapath must present `fpu_result` by the last BUSY cycle.
- Back-to-back throughput: one op per L+1 cycles.

## Configuration
- **`FPU_SQRT_EN` defined:** op 6 behaves as above with latency SQRT_LAT.
- **`FPU_SQRT_EN` undefined:**
  - op 6 is treated as illegal with L=1.
  - `wb_data`=32'h7FC00000 (canonical NaN) instead of 0.
  - `illegal`=1.
  - The SQRT_LAT parameter is unused.

## Structure
- **Package `fpu_seq_pkg`:**
  - Op encoding constants OP_FADD through OP_FCVT_SW.
  - State enum IDLE, BUSY, DONE.
  - Fixed latency constants LAT_ADD=3, LAT_MUL=4, LAT_1=1, LAT_CVT=2.
  - Canonical NaN constant.
- **Sub-module `fpu_lat_rom`:** combinational op → {L, illegal} lookup, parameterised by DIV_LAT/SQRT_LAT and `FPU_SQRT_EN`.

## Test plan
- **FADD issue:** op=0, src_a=32'h3F800000, src_b=32'h40000000, rd=5, `fpu_result` driven 32'h40400000 → `stall` high for 4 cycles (start cycle + 3 BUSY), then `wb_valid` 1 cycle later with `wb_rd`=5, `wb_data`=32'h40400000, `wb_int`=0.
- **FDIV latency:** op=3, DIV_LAT=16 → `stall` high for 17 cycles, `wb_valid` 17 cycles after `start`; `fpu_a`/`fpu_b` stable throughout.
- **Back-to-back:** FMUL then FCVT.W.S with `start` asserted in the DONE cycle, `int_dest`=1 → two `wb_valid` pulses 5 and 3 cycles apart; second has `wb_int`=1.
- **Flush in BUSY:** FSUB, `flush` at the 2nd BUSY cycle → no `wb_valid`, IDLE next cycle, `stall` low.
- **Illegal op 12:** → `wb_valid` 2 cycles after `start`, `wb_data`=0, `illegal`=1.
- **Sqrt compiled out:** with `FPU_SQRT_EN` undefined, op 6 → `wb_data`=32'h7FC00000, `illegal`=1. Reset asserted mid-FDIV → all outputs 0 immediately, no writeback.
